// File: rtl/score_display_pkg.sv
// score_display_pkg
// Shared constants for the score display: active-low segment patterns in
// {g,f,e,d,c,b,a} order, scan slot indices for the two player digits, and the
// all-anodes-off pattern. seg_decode maps a BCD digit to its segment pattern.
// Values 10-15 map to a blank pattern.
package score_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] IDX_P2 = 2'd0;
    localparam logic [1:0] IDX_P1 = 2'd3;

    localparam logic [3:0] AN_OFF = 4'b1111;

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/score_display_driver_tracker.sv
// score_digit_tracker
// Brings one player's units digit into the clk domain and decides whether
// that digit is currently visible. After a stable change is accepted, the
// digit blinks for FLASH_LEN cycles.
//   clk, reset : system clock, asynchronous active-high reset
//   digit      : raw BCD digit, asynchronous to clk
//   accepted   : synchronised, stable digit value
//   visible    : 0 while the digit is in the hidden half of a blink
module score_digit_tracker #(
    parameter int FLASH_LEN  = 50000000,
    parameter int BLINK_HALF = 6250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit,
    output logic [3:0] accepted,
    output logic       visible
);
    import score_display_pkg::*;

    localparam int FW = $clog2(FLASH_LEN + 1);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [FW-1:0] FLASH_INIT = FW'(FLASH_LEN);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [1:0]    arm_cnt;
    logic [FW-1:0] flash_cnt;
    logic [BW-1:0] blink_cnt;
    logic          hidden;

    // The synchroniser still holds its reset zeros for the first few edges
    // after release. Until the pins have propagated through s1/s2, accepted
    // simply follows s2 without flashing. Otherwise a digit held through
    // reset would register as a change from 0 and blink. Arming completes
    // once three loads have happened.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            accepted  <= '0;
            arm_cnt   <= '0;
            flash_cnt <= '0;
            blink_cnt <= '0;
            hidden    <= 1'b0;
        end else begin
            s1 <= digit;
            s2 <= s1;
            if (arm_cnt != 2'd3) begin
                arm_cnt  <= arm_cnt + 2'd1;
                accepted <= s2;
            end else if ((s1 == s2) && (s2 != accepted)) begin
                accepted  <= s2;
                flash_cnt <= FLASH_INIT;
                blink_cnt <= '0;
                hidden    <= 1'b1;
            end else if (flash_cnt != '0) begin
                flash_cnt <= flash_cnt - 1'b1;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    hidden    <= ~hidden;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // The blink phase is only meaningful while the flash window is running.
    assign visible = (flash_cnt == '0) || !hidden;

endmodule

// File: rtl/score_display_driver.sv
// score_display_driver
// Drives a 4-digit multiplexed common-anode display, showing
// "P1 - - P2" from left to right, with each player digit blinking after it
// changes.
//   clk, reset : system clock, asynchronous active-high reset
//   p1_digit   : player 1 units digit (BCD), asynchronous to clk
//   p2_digit   : player 2 units digit (BCD), asynchronous to clk
//   an         : active-low anodes, an[3] is the leftmost digit
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   dp         : active-low decimal point, always off
module score_display_driver #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int FLASH_LEN    = 50000000,
    parameter int BLINK_HALF   = 6250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] p1_digit,
    input  logic [3:0] p2_digit,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    import score_display_pkg::*;

    localparam int SW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGIT_CYCLES - 1);
    localparam logic [SW-1:0] SLOT_BLANK = SW'(BLANK_CYCLES);

    logic [SW-1:0] slot_cnt;
    logic [1:0]    idx;
    logic [3:0]    p1_value;
    logic [3:0]    p2_value;
    logic          p1_visible;
    logic          p2_visible;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    score_digit_tracker #(.FLASH_LEN(FLASH_LEN), .BLINK_HALF(BLINK_HALF)) u_p1 (
        .clk      (clk),
        .reset    (reset),
        .digit    (p1_digit),
        .accepted (p1_value),
        .visible  (p1_visible)
    );

    score_digit_tracker #(.FLASH_LEN(FLASH_LEN), .BLINK_HALF(BLINK_HALF)) u_p2 (
        .clk      (clk),
        .reset    (reset),
        .digit    (p2_digit),
        .accepted (p2_value),
        .visible  (p2_visible)
    );

    // Scan timebase: each slot lasts DIGIT_CYCLES clocks.
    // The digit index advances at the end of each slot and wraps after index 3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // All anodes stay off for the first few cycles of each slot, so the
    // previous digit's segments never briefly light the new digit position.
    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_DASH;
        if (slot_cnt >= SLOT_BLANK) begin
            an_next = ~(4'b0001 << idx);
        end
        if (idx == IDX_P2) begin
            seg_next = p2_visible ? seg_decode(p2_value) : SEG_BLANK;
        end else if (idx == IDX_P1) begin
            seg_next = p1_visible ? seg_decode(p1_value) : SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_score_display_driver.sv
// tb_score_display_driver
// Randomised plus scenario-driven bench for score_display_driver, built with
// small timing parameters. A reference model works out the expected anode and
// segment values from the display rules. It uses edge counts since reset
// release, the pin history, and the edge at which each digit last changed.
module tb_score_display_driver;

    localparam int DC = 8;
    localparam int BC = 1;
    localparam int FL = 64;
    localparam int BH = 8;

    logic       clk;
    logic       reset;
    logic [3:0] p1_pin;
    logic [3:0] p2_pin;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks;
    int failures;

    // Model state: edge count since release, plus per player (0=P1, 1=P2)
    // the accepted value, the last-change edge, and the two previous samples.
    int         k;
    logic [3:0] acc   [2];
    int         lc    [2];
    logic [3:0] hist1 [2];
    logic [3:0] hist2 [2];
    logic [6:0] dec   [16];

    score_display_driver #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC),
        .FLASH_LEN    (FL),
        .BLINK_HALF   (BH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .p1_digit (p1_pin),
        .p2_digit (p2_pin),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v1, input logic [3:0] v2);
        p1_pin = v1;
        p2_pin = v2;
    endtask

    function automatic bit modelVisible(input int last, input int j);
        int d;
        if (last < 0) return 1'b1;
        d = j - last;
        if (d >= FL) return 1'b1;
        return ((d / BH) % 2) == 1;
    endfunction

    function automatic void modelReset();
        k = 0;
        for (int p = 0; p < 2; p++) begin
            acc[p]   = 4'd0;
            lc[p]    = -1;
            hist1[p] = 4'd0;
            hist2[p] = 4'd0;
        end
    endfunction

    // Registered outputs after edge k reflect the state after edge k-1.
    task automatic checkEdge();
        int j;
        int slot;
        int pos;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        j    = k - 1;
        slot = j % DC;
        pos  = (j / DC) % 4;
        exp_an = (slot < BC) ? 4'b1111 : ~(4'b0001 << pos);
        if (pos == 0)      exp_seg = modelVisible(lc[1], j) ? dec[acc[1]] : 7'h7F;
        else if (pos == 3) exp_seg = modelVisible(lc[0], j) ? dec[acc[0]] : 7'h7F;
        else               exp_seg = 7'h3F;
        checkOutput("an", {3'b000, an}, {3'b000, exp_an});
        if (exp_an != 4'b1111) checkOutput("seg", seg, exp_seg);
        checkOutput("dp", {6'd0, dp}, 7'd1);
    endtask

    // An input value appears in the accepted digit once it has been sampled
    // twice in a row. The first three edges after release just load the
    // pipeline and never count as a change.
    task automatic modelEdge(input logic [3:0] v1, input logic [3:0] v2);
        logic [3:0] pin [2];
        pin[0] = v1;
        pin[1] = v2;
        for (int p = 0; p < 2; p++) begin
            if (k <= 3) begin
                acc[p] = hist2[p];
            end else if (hist1[p] == hist2[p] && hist2[p] != acc[p]) begin
                acc[p] = hist2[p];
                lc[p]  = k;
            end
            hist2[p] = hist1[p];
            hist1[p] = pin[p];
        end
    endtask

    task automatic cycleOnce();
        logic [3:0] v1;
        logic [3:0] v2;
        @(posedge clk);
        v1 = p1_pin;
        v2 = p2_pin;
        #1;
        k++;
        checkEdge();
        modelEdge(v1, v2);
        @(negedge clk);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) cycleOnce();
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_an", {3'b000, an}, 7'h0F);
        checkOutput("rst_seg", seg, 7'h7F);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    function automatic logic [3:0] randDigit();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        logic [3:0] a;
        logic [3:0] b;
        checks   = 0;
        failures = 0;
        dec[0] = 7'h40; dec[1] = 7'h79; dec[2] = 7'h24; dec[3] = 7'h30;
        dec[4] = 7'h19; dec[5] = 7'h12; dec[6] = 7'h02; dec[7] = 7'h78;
        dec[8] = 7'h00; dec[9] = 7'h10;
        for (int i = 10; i < 16; i++) dec[i] = 7'h7F;
        modelReset();
        reset = 1'b0;
        applyStimulus(4'd0, 4'd0);

        // Zeros through reset, then a few full scan rounds.
        $display("[TB] reset with zero digits");
        doReset();
        runCycles(80);

        // Non-zero digits held through reset must never blink.
        $display("[TB] held digits through reset");
        applyStimulus(4'd3, 4'd7);
        doReset();
        runCycles(150);

        $display("[TB] single P2 change");
        applyStimulus(4'd3, 4'd4);
        runCycles(110);

        $display("[TB] simultaneous change then P1 restart");
        applyStimulus(4'd8, 4'd1);
        runCycles(20);
        applyStimulus(4'd2, 4'd1);
        runCycles(110);

        $display("[TB] unstable P1 input");
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? 4'd5 : 4'd6, 4'd1);
            cycleOnce();
        end
        applyStimulus(4'd6, 4'd1);
        runCycles(100);

        $display("[TB] out-of-range digit and reset mid-flash");
        applyStimulus(4'd6, 4'hC);
        runCycles(70);
        applyStimulus(4'd9, 4'hC);
        runCycles(20);
        doReset();
        runCycles(100);

        $display("[TB] random stimulus");
        for (int s = 0; s < 40; s++) begin
            a = p1_pin;
            b = p2_pin;
            case ($urandom_range(0, 3))
                0: a = randDigit();
                1: b = randDigit();
                2: begin a = randDigit(); b = randDigit(); end
                default: begin
                    for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
                        applyStimulus(randDigit(), p2_pin);
                        cycleOnce();
                    end
                    a = randDigit();
                end
            endcase
            applyStimulus(a, b);
            runCycles(int'($urandom_range(1, 90)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
